// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master controller.
// Mode constants are encoded as {cpol, cpha}.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } spi_state_e;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Chip-select index width, never narrower than one bit
    function automatic int cs_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider: ticks once every div+1 cycles.
// A clear restarts the count at zero.
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: CPOL/CPHA modes, bit order, divider,
// variable length and one-hot chip selects.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W) + 1,
    parameter int NUM_CS = 1,
    parameter int DIV_W  = 8
) (
    input  logic                        sys_clk,
    input  logic                        rstn,
    input  logic                        t_start,
    output logic                        t_ready,
    output logic                        t_done,
    input  logic [DATA_W-1:0]           d_in,
    input  logic [CNT_W-1:0]            t_size,
    input  logic [cs_width(NUM_CS)-1:0] cs_sel,
    input  logic                        cpol,
    input  logic                        cpha,
    input  logic                        lsb_first,
    input  logic [DIV_W-1:0]            clk_div,
    output logic [DATA_W-1:0]           d_out,
    input  logic                        miso,
    output logic                        mosi,
    output logic                        spi_clk,
    output logic [NUM_CS-1:0]           cs_n
);

    localparam int CS_W = cs_width(NUM_CS);
    localparam logic [CNT_W-1:0] DATA_N = CNT_W'(DATA_W);

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d, n_in;
    logic [CNT_W:0]    edge_q, edge_d, k;
    logic              cpha_q, cpha_d, lsb_q, lsb_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d;
    logic              ready_q, ready_d;
    logic              tick, clr, lead, last, smp, adv;

    assign n_in = (t_size > DATA_N) ? DATA_N : t_size;
    assign clr  = (state_d != state_q);

    spi_clk_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .sys_clk(sys_clk),
        .rstn   (rstn),
        .clr    (clr),
        .div    (div_q),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        edge_d  = edge_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        div_d   = div_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        k       = edge_q + 1'b1;
        lead    = k[0];
        last    = (k == {n_q, 1'b0});
        smp     = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                sclk_d = cpol;
                if (t_start) begin
                    n_d    = n_in;
                    cpha_d = cpha;
                    lsb_d  = lsb_first;
                    div_d  = clk_div;
                    edge_d = '0;
                    rx_d   = '0;
                    if (n_in == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SETUP;
                        for (int i = 0; i < NUM_CS; i++) begin
                            cs_n_d[i] = (cs_sel != CS_W'(i));
                        end
                        // MSB-first data is left-justified so the
                        // outgoing bit is always tx_q[DATA_W-1]
                        tx_d = lsb_first ? d_in
                                         : d_in << (DATA_N - n_in);
                        mosi_d = lsb_first ? tx_d[0]
                                           : tx_d[DATA_W-1];
                    end
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    edge_d = k;
                    sclk_d = ~sclk_q;
                    smp = cpha_q ? ~lead : lead;
                    adv = cpha_q ? (lead && (k != 1))
                                 : (~lead && ~last);
                    if (smp) begin
                        rx_d = lsb_q ? {miso, rx_q[DATA_W-1:1]}
                                     : {rx_q[DATA_W-2:0], miso};
                    end
                    if (adv) begin
                        tx_d = lsb_q ? tx_q >> 1 : tx_q << 1;
                        mosi_d = lsb_q ? tx_d[0] : tx_d[DATA_W-1];
                    end
                    if (last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d  = '1;
                    dout_d  = lsb_q ? rx_q >> (DATA_N - n_q) : rx_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            n_q     <= '0;
            edge_q  <= '0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            div_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cs_n_q  <= '1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            edge_q  <= edge_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ready_q <= ready_d;
        end
    end

    assign t_ready = ready_q;
    assign t_done  = (state_q == DONE);
    assign d_out   = dout_q;
    assign mosi    = mosi_q;
    assign spi_clk = sclk_q;
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl with an SPI slave
// model, DATA_W=8 and three chip selects.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    logic       sys_clk = 1'b0;
    logic       rstn;
    logic       t_start;
    logic       t_ready;
    logic       t_done;
    logic [7:0] d_in;
    logic [3:0] t_size;
    logic [1:0] cs_sel;
    logic       cpol;
    logic       cpha;
    logic       lsb_first;
    logic [7:0] clk_div;
    logic [7:0] d_out;
    logic       miso;
    logic       mosi;
    logic       spi_clk;
    logic [2:0] cs_n;

    typedef struct {
        logic [7:0] dout;
        logic [7:0] mosi;
        int         edges;
        int         cs_low;
        logic [2:0] cs_and;
        int         lat;
        logic       cpol;
    } exp_t;

    exp_t       q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] model_dout = '0;
    logic [7:0] cur_sl = '0;

    spi_master_ctrl #(
        .DATA_W(8),
        .NUM_CS(3),
        .DIV_W (8)
    ) dut (
        .sys_clk  (sys_clk),
        .rstn     (rstn),
        .t_start  (t_start),
        .t_ready  (t_ready),
        .t_done   (t_done),
        .d_in     (d_in),
        .t_size   (t_size),
        .cs_sel   (cs_sel),
        .cpol     (cpol),
        .cpha     (cpha),
        .lsb_first(lsb_first),
        .clk_div  (clk_div),
        .d_out    (d_out),
        .miso     (miso),
        .mosi     (mosi),
        .spi_clk  (spi_clk),
        .cs_n     (cs_n)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave and monitor: drives miso, captures mosi, checks on t_done
    int         lat, edges, cs_low, si, mi;
    logic [2:0] cs_and;
    logic [7:0] mbits, m_sl;
    logic       m_cpol, m_cpha, active, done_prev;
    logic       prev_sclk, prev_mosi, is_lead;
    exp_t       e;

    always @(negedge sys_clk) begin
        if (!rstn) begin
            active    = 1'b0;
            done_prev = 1'b0;
            prev_sclk = spi_clk;
        end else begin
            if (done_prev) chk("done_pulse", 32'(t_done), 32'd0);
            done_prev = t_done;
            if (active) begin
                lat++;
                if (cs_n != 3'b111) begin
                    cs_low++;
                    cs_and &= cs_n;
                end
                if (lat == 1 && !m_cpha) begin
                    miso = m_sl[0];
                    si = 1;
                end
                if (spi_clk !== prev_sclk) begin
                    edges++;
                    is_lead = (spi_clk != m_cpol);
                    if (is_lead != m_cpha && mi < 8) begin
                        mbits[mi] = prev_mosi;
                        mi++;
                    end
                    if (is_lead == m_cpha && si < 8) begin
                        miso = m_sl[si];
                        si++;
                    end
                end
                if (t_done) begin
                    if (q.size() == 0) begin
                        chk("spurious_done", 32'(t_done), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("d_out", 32'(d_out), 32'(e.dout));
                        chk("mosi_bits", 32'(mbits), 32'(e.mosi));
                        chk("sclk_edges", 32'(edges), 32'(e.edges));
                        chk("cs_low_cycles", 32'(cs_low), 32'(e.cs_low));
                        chk("cs_pattern", 32'(cs_and), 32'(e.cs_and));
                        chk("done_latency", 32'(lat), 32'(e.lat));
                        chk("sclk_idle", 32'(spi_clk), 32'(e.cpol));
                    end
                    active = 1'b0;
                end
            end else if (t_done) begin
                chk("spurious_done", 32'(t_done), 32'd0);
            end
            prev_sclk = spi_clk;
            if (t_start && t_ready) begin
                active = 1'b1;
                lat    = 0;
                edges  = 0;
                cs_low = 0;
                cs_and = 3'b111;
                si     = 0;
                mi     = 0;
                mbits  = '0;
                m_cpol = cpol;
                m_cpha = cpha;
                m_sl   = cur_sl;
                prev_sclk = cpol;
            end
        end
        prev_mosi = mosi;
    end

    task automatic issue(input logic [7:0] d, input logic [3:0] sz,
                         input logic [1:0] cs, input logic [1:0] mode,
                         input logic lsb, input logic [7:0] div,
                         input logic [7:0] sl, input bit push);
        exp_t x;
        int   n, h, c;
        logic acc;
        n = (sz > 4'd8) ? 8 : int'(sz);
        h = int'(div) + 1;
        x.mosi = '0;
        x.dout = '0;
        for (int i = 0; i < n; i++) begin
            x.mosi[i] = lsb ? d[i] : d[n-1-i];
            if (lsb) x.dout[i] = sl[i];
            else     x.dout[n-1-i] = sl[i];
        end
        if (push) begin
            if (n == 0) x.dout = model_dout;
            model_dout = x.dout;
            x.edges  = 2 * n;
            x.cs_low = (n > 0 && cs < 3) ? (2 * n + 2) * h : 0;
            x.cs_and = (n > 0 && cs < 3) ? ~(3'b001 << cs) : 3'b111;
            x.lat    = (n > 0) ? (2 * n + 2) * h + 1 : 1;
            x.cpol   = mode[1];
            q.push_back(x);
        end
        cur_sl    = sl;
        d_in      = d;
        t_size    = sz;
        cs_sel    = cs;
        cpol      = mode[1];
        cpha      = mode[0];
        lsb_first = lsb;
        clk_div   = div;
        t_start   = 1'b1;
        c = 0;
        do begin
            acc = t_ready;
            @(posedge sys_clk);
            #1;
            c++;
        end while (!acc && c < 5000);
        t_start = 1'b0;
        chk("accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (!t_done && c < 5000) begin
            @(posedge sys_clk);
            #1;
            c++;
        end
        chk("done_seen", 32'(t_done), 32'd1);
    endtask

    task automatic run(input logic [7:0] d, input logic [3:0] sz,
                       input logic [1:0] cs, input logic [1:0] mode,
                       input logic lsb, input logic [7:0] div,
                       input logic [7:0] sl);
        issue(d, sz, cs, mode, lsb, div, sl, 1'b1);
        wait_done();
        if ($urandom_range(0, 1) == 0) begin
            repeat ($urandom_range(1, 4)) begin
                @(posedge sys_clk);
                #1;
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        t_start = 1'b0;
        d_in = '0;
        t_size = '0;
        cs_sel = '0;
        cpol = 1'b0;
        cpha = 1'b0;
        lsb_first = 1'b0;
        clk_div = '0;
        miso = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_ready", 32'(t_ready), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'h7);
        chk("rst_sclk", 32'(spi_clk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_dout", 32'(d_out), 32'd0);
        chk("rst_done", 32'(t_done), 32'd0);
        rstn = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("ready_after_rst", 32'(t_ready), 32'd1);

        run(8'hA5, 4'd8, 2'd0, SPI_MODE0, 1'b0, 8'd0, 8'h3C);
        run(8'h16, 4'd5, 2'd1, SPI_MODE3, 1'b1, 8'd3, 8'($urandom));
        run(8'($urandom), 4'd0, 2'd2, SPI_MODE0, 1'b0, 8'd0, 8'h5A);
        run(8'($urandom), 4'd12, 2'd0, SPI_MODE0, 1'b0, 8'd0,
            8'($urandom));
        run(8'($urandom), 4'd6, 2'd3, SPI_MODE2, 1'b0, 8'd1,
            8'($urandom));

        issue(8'hFF, 4'd8, 2'd1, SPI_MODE3, 1'b0, 8'd1, 8'h00, 1'b0);
        repeat (10) @(posedge sys_clk);
        #1;
        rstn = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("midrst_cs_n", 32'(cs_n), 32'h7);
        chk("midrst_sclk", 32'(spi_clk), 32'd0);
        chk("midrst_done", 32'(t_done), 32'd0);
        chk("midrst_dout", 32'(d_out), 32'd0);
        chk("midrst_ready", 32'(t_ready), 32'd0);
        rstn = 1'b1;
        model_dout = '0;
        @(posedge sys_clk);
        #1;
        chk("midrst_ready_rel", 32'(t_ready), 32'd1);
        run(8'hC3, 4'd8, 2'd2, SPI_MODE1, 1'b0, 8'd2, 8'h96);

        for (int t = 0; t < 30; t++) begin
            run(8'($urandom), 4'($urandom_range(0, 10)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)),
                8'($urandom));
        end

        repeat (4) @(posedge sys_clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
